// File: rtl/rsa_dec_pkg.sv
// Shared definitions for the RSA decryption core: controller states and default sizing.
package rsa_dec_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int MUL_CYCLES = WIDTH_DEF + 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXP      = 2'd1,
    ST_WAIT_MUL = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

endpackage

// File: rtl/mod_mul_seq.sv
// Sequential modular multiplier: a*b mod n by MSB-first interleaved shift-add-reduce.
// One load cycle on start, then WIDTH steps; done pulses while product is valid.
module mod_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int EW = WIDTH + 2;

  logic [WIDTH-1:0] a_r, b_r, n_r, acc_r, acc_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic             run_r, done_r;
  logic [EW-1:0]    n_ext_s, dbl_s, red_s, add_s;

  // one shift-add-reduce step; acc < n and b < n keep each sum below 2n
  always_comb begin
    n_ext_s   = {2'b00, n_r};
    dbl_s     = {1'b0, acc_r, 1'b0};
    red_s     = (dbl_s >= n_ext_s) ? (dbl_s - n_ext_s) : dbl_s;
    add_s     = red_s + (a_r[WIDTH-1] ? {2'b00, b_r} : EW'(0));
    acc_nxt_s = WIDTH'((add_s >= n_ext_s) ? (add_s - n_ext_s) : add_s);
  end

  // operand load, step sequencing and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      n_r    <= '0;
      acc_r  <= '0;
      cnt_r  <= '0;
      run_r  <= 1'b0;
      done_r <= 1'b0;
    end else if (start) begin
      a_r    <= a;
      b_r    <= b;
      n_r    <= n;
      acc_r  <= '0;
      cnt_r  <= CW'(WIDTH);
      run_r  <= 1'b1;
      done_r <= 1'b0;
    end else if (run_r) begin
      acc_r  <= acc_nxt_s;
      a_r    <= {a_r[WIDTH-2:0], 1'b0};
      cnt_r  <= cnt_r - CW'(1);
      run_r  <= (cnt_r != CW'(1));
      done_r <= (cnt_r == CW'(1));
    end else begin
      done_r <= 1'b0;
    end
  end

  assign done    = done_r;
  assign product = acc_r;

endmodule

// File: rtl/rsa_decrypt_core.sv
// RSA decryption core: m = c^d mod n by MSB-first square-and-multiply over mod_mul_seq.
// Define RSA_DEC_CONST_TIME_EN for the fixed-latency schedule (all bits, always multiply).
module rsa_decrypt_core
  import rsa_dec_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_load,
  input  logic [WIDTH-1:0] key_n,
  input  logic [WIDTH-1:0] key_d,
  output logic             key_ready,
  output logic             key_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             busy
);

  localparam int RW = $clog2(WIDTH + 1);

  state_e           state_r, state_nxt_s;
  logic [WIDTH-1:0] key_n_r, key_d_r, base_r, result_r, out_data_r;
  logic             key_ready_r, key_err_r, in_ready_r, out_valid_r, out_err_r, busy_r;
  logic             err_r, pos_mul_r, cur_keep_r;
  logic [RW-1:0]    rem_r, rem_nxt_s, lead_cnt_s, rem_init_s;
  logic [WIDTH-1:0] res_init_s, new_res_s, mul_a_s, mul_b_s, mul_prod_s;
  logic             pos_mul_nxt_s, keep_nxt_s, start_s, op_mul_s, finish_s, decide_s, bit_s;
  logic             accept_s, key_wr_s, key_ok_s, key_ready_nxt_s, to_done_s, mul_done_s;

  assign accept_s        = (state_r == ST_IDLE) && in_valid && in_ready_r && !key_load;
  assign key_wr_s        = (state_r == ST_IDLE) && key_load;
  assign key_ok_s        = (key_n >= WIDTH'(2));
  assign key_ready_nxt_s = key_wr_s ? key_ok_s : key_ready_r;
  assign decide_s        = ((state_r == ST_EXP) && !err_r) ||
                           ((state_r == ST_WAIT_MUL) && mul_done_s);
  // rem_r counts exponent bits still to process; the current bit is d[rem_r-1]
  assign bit_s           = |(key_d_r & (WIDTH'(1) << (rem_r - RW'(1))));
  assign new_res_s       = ((state_r == ST_WAIT_MUL) && mul_done_s && cur_keep_r) ? mul_prod_s : result_r;
  assign mul_a_s         = new_res_s;
  assign mul_b_s         = op_mul_s ? base_r : new_res_s;

  // position of the leading one of d, counted from 1 (0 when d == 0)
  always_comb begin
    lead_cnt_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      lead_cnt_s = key_d_r[i] ? RW'(i + 1) : lead_cnt_s;
    end
  end

  // starting accumulator and bit count for a new ciphertext
  always_comb begin
`ifdef RSA_DEC_CONST_TIME_EN
    res_init_s = WIDTH'(1);
    rem_init_s = RW'(WIDTH);
`else
    if (lead_cnt_s == RW'(0)) begin
      res_init_s = WIDTH'(1);
      rem_init_s = RW'(0);
    end else begin
      res_init_s = in_data;
      rem_init_s = lead_cnt_s - RW'(1);
    end
`endif
  end

  // square/multiply scheduling: choose the next product or finish
  always_comb begin
    rem_nxt_s     = rem_r;
    pos_mul_nxt_s = pos_mul_r;
    keep_nxt_s    = cur_keep_r;
    start_s       = 1'b0;
    op_mul_s      = 1'b0;
    finish_s      = 1'b0;
    if (decide_s) begin
      if (!pos_mul_r) begin
        if (rem_r == RW'(0)) begin
          finish_s = 1'b1;
        end else begin
          start_s    = 1'b1;
          keep_nxt_s = 1'b1;
`ifdef RSA_DEC_CONST_TIME_EN
          pos_mul_nxt_s = 1'b1;
`else
          // a zero bit needs no multiply, so move straight to the next square
          pos_mul_nxt_s = bit_s;
          rem_nxt_s     = bit_s ? rem_r : (rem_r - RW'(1));
`endif
        end
      end else begin
        start_s       = 1'b1;
        op_mul_s      = 1'b1;
        pos_mul_nxt_s = 1'b0;
        rem_nxt_s     = rem_r - RW'(1);
`ifdef RSA_DEC_CONST_TIME_EN
        keep_nxt_s    = bit_s;
`else
        keep_nxt_s    = 1'b1;
`endif
      end
    end else begin
      start_s = 1'b0;
    end
  end

  // controller next state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:     state_nxt_s = accept_s ? ST_EXP : ST_IDLE;
      ST_EXP:      state_nxt_s = (err_r || finish_s) ? ST_DONE : ST_WAIT_MUL;
      ST_WAIT_MUL: state_nxt_s = finish_s ? ST_DONE : ST_WAIT_MUL;
      ST_DONE:     state_nxt_s = out_ready ? ST_IDLE : ST_DONE;
      default:     state_nxt_s = ST_IDLE;
    endcase
  end

  assign to_done_s = (state_r != ST_DONE) && (state_nxt_s == ST_DONE);

  // state register with registered busy/in_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      in_ready_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      busy_r     <= (state_nxt_s != ST_IDLE);
      in_ready_r <= (state_nxt_s == ST_IDLE) && key_ready_nxt_s;
    end
  end

  // key storage; loads only while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_n_r     <= '0;
      key_d_r     <= '0;
      key_ready_r <= 1'b0;
      key_err_r   <= 1'b0;
    end else if (key_wr_s && key_ok_s) begin
      key_n_r     <= key_n;
      key_d_r     <= key_d;
      key_ready_r <= 1'b1;
      key_err_r   <= 1'b0;
    end else if (key_wr_s) begin
      key_ready_r <= 1'b0;
      key_err_r   <= 1'b1;
    end else begin
      key_ready_r <= key_ready_r;
    end
  end

  // exponentiation datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_r     <= '0;
      err_r      <= 1'b0;
      result_r   <= '0;
      rem_r      <= '0;
      pos_mul_r  <= 1'b0;
      cur_keep_r <= 1'b0;
    end else if (accept_s) begin
      base_r     <= in_data;
      err_r      <= (in_data >= key_n_r);
      result_r   <= res_init_s;
      rem_r      <= rem_init_s;
      pos_mul_r  <= 1'b0;
      cur_keep_r <= 1'b0;
    end else if (decide_s) begin
      result_r   <= new_res_s;
      rem_r      <= rem_nxt_s;
      pos_mul_r  <= pos_mul_nxt_s;
      cur_keep_r <= keep_nxt_s;
    end else begin
      result_r   <= result_r;
    end
  end

  // result presentation, held until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_err_r   <= 1'b0;
    end else if (to_done_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= err_r ? WIDTH'(0) : new_res_s;
      out_err_r   <= err_r;
    end else if ((state_r == ST_DONE) && out_ready) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_err_r   <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  mod_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_s),
    .a       (mul_a_s),
    .b       (mul_b_s),
    .n       (key_n_r),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );

  assign key_ready = key_ready_r;
  assign key_err   = key_err_r;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_err   = out_err_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_rsa_decrypt_core.sv
// Scoreboard bench for rsa_decrypt_core: a plain-arithmetic reference model queues the expected
// plaintext, error flag and latency; a negedge monitor compares whenever out_valid rises.
module tb_rsa_decrypt_core;

  localparam int WIDTH = 16;
  localparam int MULC  = WIDTH + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             key_load = 1'b0;
  logic [WIDTH-1:0] key_n = '0;
  logic [WIDTH-1:0] key_d = '0;
  logic             key_ready, key_err, in_ready, out_valid, out_err, busy;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;

  always #5 clk = ~clk;

  rsa_decrypt_core #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_n(key_n), .key_d(key_d),
    .key_ready(key_ready), .key_err(key_err), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .busy(busy)
  );

  typedef struct {
    longint data;
    longint err;
    longint lat;
    longint acc;
  } exp_t;

  exp_t   exp_q[$];
  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  int     ov_rises = 0;
  longint mdl_n = 0;
  longint mdl_d = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference: c^d mod n by repeated multiplication; latency from the multiply count
  function automatic exp_t model(input longint c);
    exp_t   e;
    longint m = 1;
    int     lead = 0;
    int     pop = 0;
    int     mcnt = 0;
    for (longint i = 0; i < mdl_d; i++) m = (m * c) % mdl_n;
    for (int i = 0; i < WIDTH; i++) begin
      if (((mdl_d >> i) & 1) == 1) begin
        lead = i;
        pop++;
      end
    end
    mcnt = (mdl_d <= 1) ? 0 : lead + pop - 1;
`ifdef RSA_DEC_CONST_TIME_EN
    mcnt = 2 * WIDTH;
`endif
    e.data = (c >= mdl_n) ? 0 : m;
    e.err  = (c >= mdl_n) ? 1 : 0;
    e.lat  = (c >= mdl_n) ? 1 : MULC * mcnt + 1;
    e.acc  = 0;
    return e;
  endfunction

  // monitor: pop and compare on every rising out_valid, then check the hold
  initial begin
    exp_t cur;
    logic prev_ov = 1'b0;
    cur = '{0, 0, 0, 0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = 1'b0;
      end else begin
        if (out_valid && !prev_ov) begin
          ov_rises++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out_valid: got data %0d, expected no output", out_data);
          end else begin
            cur = exp_q.pop_front();
            check("out_data", out_data, cur.data);
            check("out_err", out_err, cur.err);
            check("latency", cyc - cur.acc, cur.lat);
          end
        end else if (out_valid && prev_ov) begin
          check("hold_data", out_data, cur.data);
          check("hold_err", out_err, cur.err);
        end
        prev_ov = out_valid;
      end
    end
  end

  task automatic load_key(input longint n, input longint d);
    @(negedge clk);
    key_load = 1'b1;
    key_n = WIDTH'(n);
    key_d = WIDTH'(d);
    @(negedge clk);
    key_load = 1'b0;
    check("key_err", key_err, (n < 2) ? 1 : 0);
    check("key_ready", key_ready, (n < 2) ? 0 : 1);
    check("in_ready_after_load", in_ready, (n < 2) ? 0 : 1);
    if (n >= 2) begin
      mdl_n = n;
      mdl_d = d;
    end
  endtask

  task automatic send(input longint c);
    exp_t e;
    int   t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = WIDTH'(c);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: got in_ready 0 after %0d cycles, expected 1", t);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      e = model(c);
      e.acc = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic finish_op(input int hold);
    int t = 0;
    while (!out_valid && t < 1500) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) begin
      total++;
      bad++;
      $display("FAIL out_valid_timeout: got out_valid 0 after %0d cycles, expected 1", t);
    end else begin
      for (int i = 0; i < hold; i++) begin
        check("in_ready_in_done", in_ready, 0);
        check("busy_in_done", busy, 1);
        @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("out_valid_after_take", out_valid, 0);
      check("busy_after_take", busy, 0);
    end
  endtask

  initial begin
    longint n, d, c;
    int     rises0;
    repeat (3) @(negedge clk);
    check("rst_key_ready", key_ready, 0);
    check("rst_key_err", key_err, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("no_key_in_ready", in_ready, 0);

    load_key(1, 5);
    load_key(0, 3);
    load_key(33, 7);
    send(40);   finish_op(0);
    send(31);   finish_op(2);

    load_key(3233, 2753);
    send(2790); finish_op(1);
    send(855);  finish_op(20);

    // key_load while busy must not disturb the key in use
    send(2790);
    repeat (5) @(negedge clk);
    key_load = 1'b1; key_n = 16'd33; key_d = 16'd7;
    @(negedge clk);
    key_load = 1'b0;
    @(negedge clk);
    check("busy_key_ready", key_ready, 1);
    check("busy_key_err", key_err, 0);
    check("busy_during_exp", busy, 1);
    finish_op(0);
    send(855);  finish_op(0);

    load_key(3233, 0); send(1234); finish_op(0);
    load_key(3233, 1); send(1234); finish_op(0);
    load_key(65535, 65535); send(65534); finish_op(0);

    for (int k = 0; k < 12; k++) begin
      n = $urandom_range(65535, 2);
      d = (k % 3 == 0) ? $urandom_range(15, 0) : $urandom_range(65535, 0);
      load_key(n, d);
      for (int j = 0; j < 3; j++) begin
        c = ($urandom_range(4, 0) == 0) ? $urandom_range(65535, n) : $urandom_range(n - 1, 0);
        send(c);
        finish_op($urandom_range(3, 0));
      end
    end

    // reset in the middle of an exponentiation
    load_key(3233, 2753);
    send(2790);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    rises0 = ov_rises;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_key_ready", key_ready, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (700) @(negedge clk);
    check("no_valid_after_rst", ov_rises, rises0);
    check("post_rst_key_ready", key_ready, 0);
    check("post_rst_in_ready", in_ready, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rsa_decrypt_core.md
RSA_DECRYPT_CORE -- requirements
Module: rsa_decrypt_core

Interface
REQ-001 SHALL have parameter WIDTH, default 16: bit width of modulus, exponent, ciphertext and plaintext.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 key_load  in  1  single-cycle strobe that loads key_n and key_d.
REQ-006 key_n  in  WIDTH  modulus n.
REQ-007 key_d  in  WIDTH  private exponent d.
REQ-008 key_ready  out  1  high when a valid key is held.
REQ-009 key_err  out  1  high when the last load was rejected.
REQ-010 in_valid/in_ready  in/out  1  ciphertext handshake.
REQ-011 in_data  in  WIDTH  ciphertext c.
REQ-012 out_valid/out_ready  out/in  1  plaintext handshake.
REQ-013 out_data  out  WIDTH  plaintext m = c^d mod n.
REQ-014 out_err  out  1  qualifies out_data; high when c >= n.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement states IDLE, EXP (square/multiply sequencing), WAIT_MUL, DONE.
REQ-017 key_load SHALL be honoured only in IDLE and ignored otherwise; key_n < 2 sets key_err=1 and key_ready=0; otherwise the key is latched, key_err=0 and key_ready=1.
REQ-018 in_ready SHALL be 1 only in IDLE with key_ready=1; key_load and in_valid in the same IDLE cycle: the key loads, and the input is not accepted that cycle.
REQ-019 A handshake with in_data >= n SHALL go directly to DONE with out_data=0 and out_err=1, and out_valid SHALL rise on edge 1 after the accepting edge.
REQ-020 Exponentiation SHALL be MSB-first square-and-multiply, with every modular product produced by the sub-module; all operands SHALL be < n.
REQ-021 Each modular multiply SHALL take WIDTH+1 cycles (1 start cycle plus WIDTH interleaved shift-add-reduce steps).
REQ-022 out_valid SHALL rise on edge (WIDTH+1)*M+1 after the accepting edge, where M is the number of multiplies issued.
REQ-023 In DONE, out_data and out_err SHALL be held stable until out_valid and out_ready are both high, then the block SHALL return to IDLE on that edge.
REQ-024 d=0 SHALL yield out_data=1 and d=1 SHALL yield out_data=c.
REQ-025 The held key SHALL persist across operations until the next key_load or reset.

Reset
REQ-026 While rst_n=0, all outputs SHALL be 0 (key_ready=0, in_ready=0, out_valid=0, busy=0), state SHALL be IDLE and the key SHALL be cleared.
REQ-027 Reset during EXP, WAIT_MUL or DONE SHALL abort the operation; no out_valid SHALL follow and a new key_load is required.

Configuration
REQ-028 Macro RSA_DEC_CONST_TIME_EN: when defined, the block SHALL start with result=1 and process all WIDTH exponent bits, always squaring and always multiplying, and SHALL discard the multiply when the bit is 0; M=2*WIDTH (latency 545 at WIDTH=16).
REQ-029 When RSA_DEC_CONST_TIME_EN is undefined, the block SHALL skip leading zeros of d, set result=c at the leading one, and for each remaining bit square, then multiply only if the bit is 1; M = (bits below leading one) + popcount(d) - 1, and M=0 for d<=1.

Structure
REQ-030 Package rsa_dec_pkg SHALL hold the state enum, the WIDTH default and MUL_CYCLES=WIDTH+1.
REQ-031 One sub-module mod_mul_seq SHALL be used, with start/done, a, b, n and a product output.

Verification
REQ-032 Load n=3233, d=2753, then ciphertext 2790 -> out_data=65, out_err=0; latency 256 (not CONST_TIME) or 545 (CONST_TIME).
REQ-033 Same key, ciphertext 855 -> out_data=123; then n=33, d=7, ciphertext 31 -> out_data=4.
REQ-034 key_load with n=1 -> key_err=1, key_ready=0, in_ready stays 0; then n=33 -> key_err=0.
REQ-035 n=33, ciphertext 40 -> out_err=1, out_data=0, out_valid on edge 1.
REQ-036 Hold out_ready=0 for 20 cycles in DONE -> out_data stable, in_ready=0; key_load during EXP is ignored.
REQ-037 Assert rst_n=0 mid-EXP -> all outputs 0, key_ready=0, and no out_valid after release.
